irrigation_scheduler_fsm: RTL and testbench

Parametrised successor to the single-tank watering/filling controller. Serves ZONES irrigation zones from one tank. Each zone requests either dripper or sprinkler mode. The block arbitrates zones round-robin with a per-zone watering time limit, refills the tank using low/high level hysteresis, and enters a sticky FAULT state on fill timeout. It sits between the zone sensor/request logic and the valve/pump drivers.

---
 rtl/irrigation_scheduler_fsm_if.sv | 30 +++
 rtl/irrigation_scheduler_fsm.sv | 160 ++++++++++++++++
 tb/tb_irrigation_scheduler_fsm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/irrigation_scheduler_fsm_if.sv
// Bundles the zone/tank inputs and the valve/pump outputs of the irrigation scheduler.
interface irrigation_scheduler_fsm_if #(
  parameter int ZONES   = 4,
  parameter int LEVEL_W = 8
);
  localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;

  logic               tick;
  logic [LEVEL_W-1:0] tank_level;
  logic [ZONES-1:0]   dripper;
  logic [ZONES-1:0]   sprinkler;
  logic               watering;
  logic               filling;
  logic               fault;
  logic [1:0]         state;
  logic [ZW-1:0]      active_zone;
  logic [ZONES-1:0]   zone_valve;
  logic               mode;
  logic [ZONES-1:0]   zone_error;

  modport master (
    output tick, tank_level, dripper, sprinkler,
    input  watering, filling, fault, state, active_zone, zone_valve, mode, zone_error
  );

  modport slave (
    input  tick, tank_level, dripper, sprinkler,
    output watering, filling, fault, state, active_zone, zone_valve, mode, zone_error
  );
endinterface

// File: rtl/irrigation_scheduler_fsm.sv
// Multi-zone irrigation scheduler: round-robin zone grants with a watering time limit,
// hysteretic tank refill, and a sticky fault on refill timeout.
module irrigation_zone_lane (
  input  logic clock,
  input  logic reset,
  input  logic drip_i,
  input  logic spr_i,
  output logic req_o,
  output logic err_o
);
  logic err_q;

  // A zone asking for both modes at once is treated as broken, not as a request.
  assign req_o = drip_i ^ spr_i;
  assign err_o = err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= drip_i & spr_i;
  end
endmodule

module irrigation_scheduler_fsm #(
  parameter int ZONES       = 4,
  parameter int LEVEL_W     = 8,
  parameter int LOW_LEVEL   = 64,
  parameter int HIGH_LEVEL  = 224,
  parameter int WATER_TICKS = 100,
  parameter int FILL_TICKS  = 1000,
  parameter int TIMER_W     = 16
) (
  input logic                    clock,
  input logic                    reset,
  irrigation_scheduler_fsm_if.slave bus
);
  localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WATERING = 2'b01,
    FILLING  = 2'b10,
    FAULT    = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [ZW-1:0]      zone_q, zone_d;
  logic [ZW-1:0]      ptr_q, ptr_d;
  logic               mode_q, mode_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [ZONES-1:0]   valve_q, valve_d;

  logic [ZONES-1:0]   req, err;
  logic [ZW-1:0]      grant, zone_nxt;
  logic [TIMER_W-1:0] timer_inc;
  logic               fill_need, full, req_lost;

  for (genvar i = 0; i < ZONES; i++) begin : g_lane
    irrigation_zone_lane u_lane (
      .clock  (clock),
      .reset  (reset),
      .drip_i (bus.dripper[i]),
      .spr_i  (bus.sprinkler[i]),
      .req_o  (req[i]),
      .err_o  (err[i])
    );
  end

  assign fill_need = bus.tank_level <  LEVEL_W'(LOW_LEVEL);
  assign full      = bus.tank_level >= LEVEL_W'(HIGH_LEVEL);
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
  assign zone_nxt  = (zone_q == ZW'(ZONES - 1)) ? '0 : zone_q + ZW'(1);
  // Grant ends if the zone stopped asking or flipped between dripper and sprinkler.
  assign req_lost  = !req[zone_q] || (bus.sprinkler[zone_q] != mode_q);

  // First requesting zone at or after the pointer, wrapping around.
  always_comb begin
    logic found;
    found = 1'b0;
    grant = ptr_q;
    for (int k = 0; k < ZONES; k++) begin
      if (!found && req[(int'(ptr_q) + k) % ZONES]) begin
        found = 1'b1;
        grant = ZW'((int'(ptr_q) + k) % ZONES);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    ptr_d   = ptr_q;
    mode_d  = mode_q;
    timer_d = timer_q;
    valve_d = '0;
    case (state_q)
      IDLE: begin
        if (fill_need) begin
          state_d = FILLING;
          timer_d = '0;
        end else if (|req) begin
          state_d = WATERING;
          zone_d  = grant;
          mode_d  = bus.sprinkler[grant];
          timer_d = '0;
          valve_d = ZONES'(1) << grant;
        end
      end
      WATERING: begin
        if (bus.tick) timer_d = timer_inc;
        valve_d = ZONES'(1) << zone_q;
        // Pointer is left alone on a refill abort so the same zone goes first afterwards.
        if (fill_need) begin
          state_d = FILLING;
          timer_d = '0;
          valve_d = '0;
        end else if (req_lost || (bus.tick && timer_q == TIMER_W'(WATER_TICKS - 1))) begin
          state_d = IDLE;
          ptr_d   = zone_nxt;
          valve_d = '0;
        end
      end
      FILLING: begin
        if (bus.tick) timer_d = timer_inc;
        if (full)
          state_d = IDLE;
        else if (bus.tick && timer_q == TIMER_W'(FILL_TICKS - 1))
          state_d = FAULT;
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      zone_q  <= '0;
      ptr_q   <= '0;
      mode_q  <= 1'b0;
      timer_q <= '0;
      valve_q <= '0;
    end else begin
      state_q <= state_d;
      zone_q  <= zone_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      timer_q <= timer_d;
      valve_q <= valve_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.watering    = (state_q == WATERING);
  assign bus.filling     = (state_q == FILLING);
  assign bus.fault       = (state_q == FAULT);
  assign bus.active_zone = zone_q;
  assign bus.mode        = mode_q;
  assign bus.zone_valve  = valve_q;
  assign bus.zone_error  = err;
endmodule

// File: tb/tb_irrigation_scheduler_fsm.sv
// Directed vector bench for the irrigation scheduler with small time limits.
module tb_irrigation_scheduler_fsm;
  localparam int ZONES = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   passed = 0;
  int   total  = 0;

  irrigation_scheduler_fsm_if #(.ZONES(ZONES), .LEVEL_W(8)) ifc ();

  irrigation_scheduler_fsm #(
    .ZONES(ZONES), .LEVEL_W(8), .LOW_LEVEL(64), .HIGH_LEVEL(224),
    .WATER_TICKS(3), .FILL_TICKS(5), .TIMER_W(16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       tk;
    logic [7:0] lvl;
    logic [3:0] d;
    logic [3:0] s;
    logic [1:0] st;
    logic [1:0] z;
    logic       m;
    logic [3:0] err;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_state(input string nm, input logic [1:0] st);
    chk({nm, ".state"},    int'(ifc.state), int'(st));
    chk({nm, ".watering"}, int'(ifc.watering), int'(st == 2'b01));
    chk({nm, ".filling"},  int'(ifc.filling),  int'(st == 2'b10));
    chk({nm, ".fault"},    int'(ifc.fault),    int'(st == 2'b11));
  endtask

  task automatic drive(input logic tk, input logic [7:0] lvl, input logic [3:0] d, input logic [3:0] s);
    ifc.tick = tk; ifc.tank_level = lvl; ifc.dripper = d; ifc.sprinkler = s;
  endtask

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  // Valves are at most one-hot and never switch zone without passing through all-off.
  logic [3:0] prev_valve = '0;
  always @(negedge clock) begin
    if (reset) begin
      chk("valve_onehot", int'($countones(ifc.zone_valve) <= 1), 1);
      if (prev_valve != 0 && ifc.zone_valve != 0)
        chk("valve_overlap", int'(ifc.zone_valve), int'(prev_valve));
      prev_valve = ifc.zone_valve;
    end else prev_valve = '0;
  end

  vec_t vt[$];

  initial begin
    logic [3:0] exp_valve;
    vt = '{
      '{0, 200, 4'b0001, 4'b0000, 2'b01, 2'd0, 0, 4'b0000},  // first grant zone 0
      '{1, 200, 4'b0001, 4'b0000, 2'b01, 2'd0, 0, 4'b0000},
      '{1, 200, 4'b0001, 4'b0000, 2'b01, 2'd0, 0, 4'b0000},
      '{1, 200, 4'b0001, 4'b0000, 2'b00, 2'd0, 0, 4'b0000},  // 3rd tick ends grant
      '{0, 200, 4'b0101, 4'b0000, 2'b01, 2'd2, 0, 4'b0000},  // rr moves to zone 2
      '{1, 200, 4'b0101, 4'b0000, 2'b01, 2'd2, 0, 4'b0000},
      '{1, 200, 4'b0101, 4'b0000, 2'b01, 2'd2, 0, 4'b0000},
      '{1, 200, 4'b0101, 4'b0000, 2'b00, 2'd2, 0, 4'b0000},
      '{0, 200, 4'b0101, 4'b0000, 2'b01, 2'd0, 0, 4'b0000},  // wrap back to zone 0
      '{0, 200, 4'b0100, 4'b0001, 2'b00, 2'd0, 0, 4'b0000},  // mode change ends grant
      '{0, 200, 4'b0100, 4'b0001, 2'b01, 2'd2, 0, 4'b0000},
      '{0, 200, 4'b0000, 4'b0001, 2'b00, 2'd2, 0, 4'b0000},  // request dropped
      '{0, 200, 4'b0000, 4'b0001, 2'b01, 2'd0, 1, 4'b0000},  // sprinkler grant
      '{0,  50, 4'b0000, 4'b0001, 2'b10, 2'd0, 0, 4'b0000},  // refill aborts grant
      '{1, 150, 4'b0000, 4'b0001, 2'b10, 2'd0, 0, 4'b0000},  // hysteresis band
      '{0, 224, 4'b0000, 4'b0001, 2'b00, 2'd0, 0, 4'b0000},
      '{0, 224, 4'b0010, 4'b0001, 2'b01, 2'd0, 1, 4'b0000},  // aborted zone served first
      '{0, 224, 4'b0010, 4'b0011, 2'b01, 2'd0, 1, 4'b0010},  // zone 1 error, zone 0 runs on
      '{0, 224, 4'b0000, 4'b0000, 2'b00, 2'd0, 0, 4'b0000},
      '{0, 224, 4'b0010, 4'b0010, 2'b00, 2'd0, 0, 4'b0010},  // both bits: no grant
      '{0,  64, 4'b0000, 4'b0000, 2'b00, 2'd0, 0, 4'b0000},  // 64 is not below LOW
      '{0,  63, 4'b0000, 4'b0000, 2'b10, 2'd0, 0, 4'b0000},
      '{0, 223, 4'b0000, 4'b0000, 2'b10, 2'd0, 0, 4'b0000}   // 223 is not full
    };

    drive(0, 200, '0, '0);
    repeat (2) cyc();
    chk_state("reset", 2'b00);
    chk("reset.valve", int'(ifc.zone_valve), 0);
    chk("reset.zone",  int'(ifc.active_zone), 0);
    chk("reset.mode",  int'(ifc.mode), 0);
    chk("reset.err",   int'(ifc.zone_error), 0);

    reset = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      drive(vt[i].tk, vt[i].lvl, vt[i].d, vt[i].s);
      cyc();
      exp_valve = (vt[i].st == 2'b01) ? (4'b0001 << vt[i].z) : 4'b0000;
      chk_state(nm, vt[i].st);
      chk({nm, ".valve"}, int'(ifc.zone_valve), int'(exp_valve));
      chk({nm, ".err"},   int'(ifc.zone_error), int'(vt[i].err));
      if (vt[i].st == 2'b01) begin
        chk({nm, ".zone"}, int'(ifc.active_zone), int'(vt[i].z));
        chk({nm, ".mode"}, int'(ifc.mode), int'(vt[i].m));
      end
    end

    // Full level wins over the timeout tick on the same cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1, 10, '0, '0); cyc();
      chk_state($sformatf("fillA%0d", i), 2'b10);
    end
    drive(1, 230, '0, '0); cyc();
    chk_state("full_vs_timeout", 2'b00);

    // Five ticks in FILLING without reaching full -> sticky FAULT.
    drive(0, 10, '0, '0); cyc();
    chk_state("fillB_entry", 2'b10);
    for (int i = 0; i < 4; i++) begin
      drive(1, 10, '0, '0); cyc();
      chk_state($sformatf("fillB%0d", i), 2'b10);
    end
    drive(1, 10, '0, '0); cyc();
    chk_state("timeout", 2'b11);
    for (int i = 0; i < 3; i++) begin
      drive(1, 230, 4'b0001, '0); cyc();
      chk_state($sformatf("sticky%0d", i), 2'b11);
      chk($sformatf("sticky%0d.valve", i), int'(ifc.zone_valve), 0);
    end

    // Reset clears FAULT without a clock edge.
    reset = 1'b0; #2;
    chk_state("async_rst_fault", 2'b00);
    cyc();
    reset = 1'b1;
    drive(0, 200, 4'b0100, '0); cyc();
    chk_state("post_rst_grant", 2'b01);
    chk("post_rst_grant.zone",  int'(ifc.active_zone), 2);
    chk("post_rst_grant.valve", int'(ifc.zone_valve), 4);

    // Reset mid-watering drops the valve immediately.
    reset = 1'b0; #2;
    chk_state("async_rst_water", 2'b00);
    chk("async_rst_water.valve", int'(ifc.zone_valve), 0);
    cyc();
    reset = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
